// File: rtl/ahb_timer.sv
// ahb_timer: AHB-Lite slave countdown timer (LOAD/VALUE/CTRL/STATUS) with a level interrupt.
// Latency: zero wait states; register writes are visible the cycle after their data phase; IRQ follows the expiring tick by one cycle.
// Backpressure: none. HREADYOUT is tied high and the slave never stalls the bus.
//
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   HSEL, HREADY, HADDR,   AHB-Lite address phase (only HADDR[ADDR_W-1:2] decoded,
//   HTRANS, HWRITE, HSIZE  only word-sized writes honoured)
//   HWDATA                 write data, taken in the data phase
//   HRDATA, HREADYOUT      read data (0 outside a valid data phase), always-ready
//   TIMER_IRQ              STATUS & CTRL.IE
//   EXTIN                  external tick source (only with TIMER_EXTIN_EN defined)
module ahb_timer #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
`ifdef TIMER_EXTIN_EN
  input  logic        EXTIN,
`endif
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        TIMER_IRQ
);

  localparam int AW = ADDR_W - 2;

`ifdef TIMER_EXTIN_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h1F;
`endif

  typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

  // Bus pipeline registers (address phase -> data phase)
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          word_q;
  logic          vld_q;

  // Timer state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic             status_q, status_d;
  logic [7:0]       presc_q, presc_d;

  logic accept;
  logic wr_ok, wr_load, wr_ctrl, wr_clr;
  logic running;
  logic presc_tick;
  logic tick;

  logic unused_bits;
  assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign wr_ok   = vld_q & wr_q & word_q;
  assign wr_load = wr_ok & (addr_q == AW'(0));
  assign wr_ctrl = wr_ok & (addr_q == AW'(2));
  assign wr_clr  = wr_ok & (addr_q == AW'(3));
  assign running = (state_q == ST_RUNNING);

  always_comb begin
    presc_tick = 1'b0;
    case (ctrl_q[3:2])
      2'b00:   presc_tick = 1'b1;
      2'b01:   presc_tick = (presc_q[3:0] == 4'hF);
      default: presc_tick = (presc_q == 8'hFF);
    endcase
  end

`ifdef TIMER_EXTIN_EN
  // Two-flop synchronizer plus one extra stage for rising-edge detection.
  logic ext_s1_q, ext_s2_q, ext_s3_q;
  logic ext_rise;
  assign ext_rise = ext_s2_q & ~ext_s3_q;
  assign tick     = ctrl_q[5] ? ext_rise : presc_tick;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ext_s1_q <= 1'b0;
      ext_s2_q <= 1'b0;
      ext_s3_q <= 1'b0;
    end else begin
      ext_s1_q <= EXTIN;
      ext_s2_q <= ext_s1_q;
      ext_s3_q <= ext_s2_q;
    end
  end
`else
  assign tick = presc_tick;
`endif

  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    value_d  = value_q;
    ctrl_d   = ctrl_q;
    status_d = status_q;

    // Any CTRL write rewrites PRESC, so it restarts the prescaler phase.
    presc_d = (!running || wr_ctrl) ? 8'd0 : presc_q + 8'd1;

    if (wr_ctrl) ctrl_d   = HWDATA[5:0] & CTRL_MASK;
    if (wr_clr)  status_d = 1'b0;
    if (wr_load) begin
      load_d  = HWDATA[CNT_W-1:0];
      value_d = HWDATA[CNT_W-1:0];
    end

    case (state_q)
      ST_STOPPED: begin
        if (ctrl_d[0]) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        // A LOAD write in the same cycle swallows the tick entirely.
        if (tick && !wr_load) begin
          if (value_q != '0) begin
            value_d = value_q - CNT_W'(1);
          end else begin
            // Expiry overrides a same-cycle CLEAR; applied after any CTRL
            // write so a one-shot expiry always drops EN.
            status_d = 1'b1;
            if (ctrl_q[1]) begin
              value_d   = '0;
              ctrl_d[0] = 1'b0;
            end else begin
              value_d = load_q;
            end
          end
        end
        if (!ctrl_d[0]) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      word_q   <= 1'b0;
      vld_q    <= 1'b0;
      state_q  <= ST_STOPPED;
      load_q   <= '0;
      value_q  <= '0;
      ctrl_q   <= '0;
      status_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        addr_q <= HADDR[ADDR_W-1:2];
        wr_q   <= HWRITE;
        word_q <= (HSIZE == 3'b010);
      end
      state_q  <= state_d;
      load_q   <= load_d;
      value_q  <= value_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      presc_q  <= presc_d;
    end
  end

  // Reads show the registers as they stand this cycle (pre-update).
  always_comb begin
    HRDATA = '0;
    if (vld_q) begin
      case (addr_q)
        AW'(0):  HRDATA = 32'(load_q);
        AW'(1):  HRDATA = 32'(value_q);
        AW'(2):  HRDATA = {26'd0, ctrl_q};
        AW'(3):  HRDATA = {31'd0, status_q};
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign TIMER_IRQ = status_q & ctrl_q[4];

endmodule
